// File: rtl/simple_pkg.sv
// Shared encodings for the branch/flag unit: condition codes, flag bit
// positions within {S,Z,C,V}, and the branch FSM state type.
package simple_pkg;

  localparam int unsigned FLAG_S = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [2:0] {
    COND_EQ     = 3'b000,
    COND_LT     = 3'b001,
    COND_LE     = 3'b010,
    COND_NE     = 3'b011,
    COND_ALWAYS = 3'b100,
    COND_CS     = 3'b101,
    COND_MI     = 3'b110,
    COND_NEVER  = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOLD = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch condition evaluation against an {S,Z,C,V} flag word.
module cond_eval
  import simple_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [2:0] cond,
  output logic       taken
);

  logic s, z, c, v;

  always_comb begin
    s     = flags[FLAG_S];
    z     = flags[FLAG_Z];
    c     = flags[FLAG_C];
    v     = flags[FLAG_V];
    taken = 1'b0;
    unique case (cond_e'(cond))
      COND_EQ:     taken = z;
      COND_LT:     taken = s ^ v;
      COND_LE:     taken = z | (s ^ v);
      COND_NE:     taken = ~z;
      COND_ALWAYS: taken = 1'b1;
      COND_CS:     taken = c;
      COND_MI:     taken = s;
      COND_NEVER:  taken = 1'b0;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_flag_unit.sv
// Flag register plus a single-entry branch resolver with valid/ready
// handshakes on both the request and result sides.
module branch_flag_unit
  import simple_pkg::*;
#(
  parameter int DISP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        szcv_in,
  input  logic              flag_we,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_cond,
  input  logic [DISP_W-1:0] br_disp,
  input  logic [15:0]       pc,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              taken,
  output logic [15:0]       target,
  output logic [3:0]        flags
);

  state_e            state;
  logic [2:0]        cond_q;
  logic [DISP_W-1:0] disp_q;
  logic [15:0]       pc_q;

  logic [2:0]        cond_sel;
  logic [DISP_W-1:0] disp_sel;
  logic [15:0]       pc_sel;
  logic signed [15:0] disp_ext;
  logic [15:0]       next_pc;
  logic [15:0]       br_target;
  logic              eval_taken;

  // Reset gates ready so no request can be accepted while rst is held.
  assign br_ready = (state == ST_IDLE) & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags <= '0;
    else if (flag_we) flags <= szcv_in;
  end

  // One evaluator serves both paths: live request in IDLE, latched one in HOLD.
  always_comb begin
    cond_sel  = (state == ST_IDLE) ? br_cond : cond_q;
    disp_sel  = (state == ST_IDLE) ? br_disp : disp_q;
    pc_sel    = (state == ST_IDLE) ? pc      : pc_q;
    disp_ext  = 16'(signed'(disp_sel));
    next_pc   = pc_sel + 16'd1;
    br_target = next_pc + disp_ext;
  end

  cond_eval u_cond_eval (
    .flags (flags),
    .cond  (cond_sel),
    .taken (eval_taken)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      res_valid <= 1'b0;
      taken     <= 1'b0;
      target    <= '0;
      cond_q    <= '0;
      disp_q    <= '0;
      pc_q      <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (br_valid) begin
            cond_q <= br_cond;
            disp_q <= br_disp;
            pc_q   <= pc;
            if (flag_we) begin
              state <= ST_HOLD;
            end else begin
              taken     <= eval_taken;
              target    <= eval_taken ? br_target : next_pc;
              res_valid <= 1'b1;
              state     <= ST_RESP;
            end
          end
        end
        ST_HOLD: begin
          taken     <= eval_taken;
          target    <= eval_taken ? br_target : next_pc;
          res_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_flag_unit.sv
// Directed bench for branch_flag_unit: flag writes, all conditions,
// HOLD path latency, result back-pressure, PC wrap and mid-request reset.
module tb_branch_flag_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  szcv_in;
  logic        flag_we;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_cond;
  logic [7:0]  br_disp;
  logic [15:0] pc;
  logic        res_valid;
  logic        res_ready;
  logic        taken;
  logic [15:0] target;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_flag_unit #(.DISP_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .szcv_in   (szcv_in),
    .flag_we   (flag_we),
    .br_valid  (br_valid),
    .br_ready  (br_ready),
    .br_cond   (br_cond),
    .br_disp   (br_disp),
    .pc        (pc),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .taken     (taken),
    .target    (target),
    .flags     (flags)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_flags(input logic [3:0] v);
    szcv_in = v;
    flag_we = 1'b1;
    step();
    flag_we = 1'b0;
  endtask

  task automatic issue(input logic [2:0] c, input logic [7:0] d, input logic [15:0] p);
    br_cond  = c;
    br_disp  = d;
    pc       = p;
    br_valid = 1'b1;
    step();
    br_valid = 1'b0;
  endtask

  task automatic consume();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    szcv_in = '0; flag_we = 0; br_valid = 0; br_cond = '0; br_disp = '0;
    pc = '0; res_ready = 0;
    #12;
    n_checks++;
    if (br_ready !== 1'b0) begin n_fail++; $display("FAIL reset_br_ready got %b want 0", br_ready); end
    n_checks++;
    if ({res_valid, taken, target, flags} !== 22'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got rv=%b tk=%b tg=%h fl=%b want all zero", res_valid, taken, target, flags);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (br_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_br_ready got %b want 1", br_ready); end
    step();
  endtask

  task automatic test_eq_taken();
    write_flags(4'b0100);
    n_checks++;
    if (flags !== 4'b0100) begin n_fail++; $display("FAIL flag_write got %b want 0100", flags); end
    issue(3'b000, 8'd5, 16'h0010);
    n_checks++;
    if ({res_valid, taken, target, br_ready} !== {1'b1, 1'b1, 16'h0016, 1'b0}) begin
      n_fail++;
      $display("FAIL eq_taken got rv=%b tk=%b tg=%h rdy=%b want 1 1 0016 0", res_valid, taken, target, br_ready);
    end
    consume();
    n_checks++;
    if ({res_valid, br_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL eq_consume got rv=%b rdy=%b want 0 1", res_valid, br_ready);
    end
  endtask

  task automatic test_le_ne();
    write_flags(4'b1000);
    issue(3'b010, 8'hFC, 16'h0020);
    n_checks++;
    if ({res_valid, taken, target} !== {1'b1, 1'b1, 16'h001D}) begin
      n_fail++;
      $display("FAIL le_neg_disp got rv=%b tk=%b tg=%h want 1 1 001D", res_valid, taken, target);
    end
    consume();
    write_flags(4'b0100);
    issue(3'b011, 8'hFC, 16'h0020);
    n_checks++;
    if ({res_valid, taken, target} !== {1'b1, 1'b0, 16'h0021}) begin
      n_fail++;
      $display("FAIL ne_not_taken got rv=%b tk=%b tg=%h want 1 0 0021", res_valid, taken, target);
    end
    consume();
  endtask

  task automatic test_conditions();
    // {flags, cond, expected taken}; pc=0100, disp=+16 -> 0111 taken / 0101 not
    logic [7:0] vec [8];
    vec[0] = {4'b0001, 3'b001, 1'b1};
    vec[1] = {4'b1001, 3'b001, 1'b0};
    vec[2] = {4'b0010, 3'b101, 1'b1};
    vec[3] = {4'b1101, 3'b101, 1'b0};
    vec[4] = {4'b1000, 3'b110, 1'b1};
    vec[5] = {4'b1111, 3'b111, 1'b0};
    vec[6] = {4'b0000, 3'b100, 1'b1};
    vec[7] = {4'b0000, 3'b010, 1'b0};
    for (int i = 0; i < 8; i++) begin
      logic [7:0]  v;
      logic [15:0] exp_tg;
      v = vec[i];
      exp_tg = v[0] ? 16'h0111 : 16'h0101;
      write_flags(v[7:4]);
      issue(v[3:1], 8'h10, 16'h0100);
      n_checks++;
      if ({res_valid, taken, target} !== {1'b1, v[0], exp_tg}) begin
        n_fail++;
        $display("FAIL cond_vec%0d got rv=%b tk=%b tg=%h want 1 %b %h", i, res_valid, taken, target, v[0], exp_tg);
      end
      consume();
    end
  endtask

  task automatic test_hold_path();
    write_flags(4'b0000);
    szcv_in  = 4'b0100;
    flag_we  = 1'b1;
    br_cond  = 3'b000;
    br_disp  = 8'd2;
    pc       = 16'h0030;
    br_valid = 1'b1;
    step();
    flag_we  = 1'b0;
    br_valid = 1'b0;
    n_checks++;
    if ({res_valid, br_ready, flags} !== {1'b0, 1'b0, 4'b0100}) begin
      n_fail++;
      $display("FAIL hold_cycle got rv=%b rdy=%b fl=%b want 0 0 0100", res_valid, br_ready, flags);
    end
    step();
    n_checks++;
    if ({res_valid, taken, target} !== {1'b1, 1'b1, 16'h0033}) begin
      n_fail++;
      $display("FAIL hold_result got rv=%b tk=%b tg=%h want 1 1 0033", res_valid, taken, target);
    end
    write_flags(4'b0000);
    n_checks++;
    if ({res_valid, taken, target, flags} !== {1'b1, 1'b1, 16'h0033, 4'b0000}) begin
      n_fail++;
      $display("FAIL resp_flag_write got rv=%b tk=%b tg=%h fl=%b want 1 1 0033 0000", res_valid, taken, target, flags);
    end
    consume();
  endtask

  task automatic test_wrap_stall();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    n_checks++;
    if ({res_valid, br_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL idle_res_ready got rv=%b rdy=%b want 0 1", res_valid, br_ready);
    end
    issue(3'b100, 8'h01, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      br_valid = 1'b1;
      n_checks++;
      if ({res_valid, taken, target, br_ready} !== {1'b1, 1'b1, 16'h0001, 1'b0}) begin
        n_fail++;
        $display("FAIL wrap_stall%0d got rv=%b tk=%b tg=%h rdy=%b want 1 1 0001 0", i, res_valid, taken, target, br_ready);
      end
      step();
    end
    br_valid = 1'b0;
    consume();
    n_checks++;
    if ({res_valid, br_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL wrap_release got rv=%b rdy=%b want 0 1", res_valid, br_ready);
    end
  endtask

  task automatic test_reset_mid();
    write_flags(4'b0101);
    issue(3'b100, 8'h04, 16'h0200);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({res_valid, taken, target, flags, br_ready} !== 23'h0) begin
      n_fail++;
      $display("FAIL mid_reset got rv=%b tk=%b tg=%h fl=%b rdy=%b want all zero", res_valid, taken, target, flags, br_ready);
    end
    #4;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({res_valid, br_ready} !== 2'b01) begin
        n_fail++;
        $display("FAIL post_mid_reset%0d got rv=%b rdy=%b want 0 1", i, res_valid, br_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_eq_taken();
    test_le_ne();
    test_conditions();
    test_hold_path();
    test_wrap_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
